// File: rtl/mul_fp32_if.sv
// Operand/result bundle for the iterative binary32 multiplier.
// The issue side drives operands and rounding mode; the unit returns the
// product and the exception flags shared with the divider.
interface mul_fp32_if;
  logic        valid_in;
  logic [2:0]  rm;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        valid_out;
  logic [31:0] product;
  logic        nv;
  logic        dz;
  logic        of;
  logic        uf;
  logic        nx;

  modport master (
    output valid_in, rm, multiplicand, multiplier,
    input  valid_out, product, nv, dz, of, uf, nx
  );

  modport slave (
    input  valid_in, rm, multiplicand, multiplier,
    output valid_out, product, nv, dz, of, uf, nx
  );
endinterface

// File: rtl/mul_fp32.sv
// Iterative IEEE-754 binary32 multiplier: radix-2 shift-add significand
// product over 24 cycles, then one normalize/round cycle. Latency is fixed
// for every operand class, so specials ride through the same pipeline.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready, waiting for valid_in
// UNPACK | classify operands, normalize subnormals, sum exponents
// MUL    | one shift-add step per cycle, counter 0..23
// ROUND  | normalize, gradual underflow, round, overflow select
// DONE   | valid_out pulse; also ready so a new op can issue here
module mul_fp32 #(
  parameter int LATENCY = 26
) (
  input  logic      clock,
  input  logic      reset,
  mul_fp32_if.slave bus
);
  localparam int          MUL_CYCLES = LATENCY - 2;
  localparam logic [4:0]  CNT_LAST   = 5'(MUL_CYCLES - 1);
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_ROUND, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               w_accept;

  logic [2:0]         r_rm;
  logic [31:0]        r_a, r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mcand;
  logic [47:0]        r_acc;
  logic [4:0]         r_cnt;
  logic               r_special;
  logic [31:0]        r_spec_res;
  logic               r_spec_nv;

  logic [31:0]        r_product;
  logic               r_nv, r_of, r_uf, r_nx;

  // Leading-zero count of a 24-bit significand (highest set bit wins).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 24; i++)
      if (v[i]) n = 5'(23 - i);
    return n;
  endfunction

  // Significand with the leading one moved to bit 23 (subnormals shifted up).
  function automatic logic [23:0] unpack_sig(input logic [31:0] f);
    logic [23:0] s;
    if (f[30:23] != 8'd0) s = {1'b1, f[22:0]};
    else                  s = {1'b0, f[22:0]} << lzc24({1'b0, f[22:0]});
    return s;
  endfunction

  // Biased exponent matching unpack_sig; subnormals go to 1 - shift.
  function automatic logic signed [9:0] unpack_exp(input logic [31:0] f);
    logic signed [9:0] e;
    if (f[30:23] != 8'd0) e = $signed({2'b00, f[30:23]});
    else                  e = 10'sd1 - $signed({5'd0, lzc24({1'b0, f[22:0]})});
    return e;
  endfunction

  // Operand classification and special-result selection.
  logic              w_a_zero, w_a_inf, w_a_nan, w_a_snan;
  logic              w_b_zero, w_b_inf, w_b_nan, w_b_snan;
  logic              w_sign;
  logic signed [9:0] w_exp_sum;
  logic              w_spec, w_spec_nv;
  logic [31:0]       w_spec_res;

  assign w_a_zero  = (r_a[30:0] == 31'd0);
  assign w_a_inf   = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_a_nan   = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_a_snan  = w_a_nan && !r_a[22];
  assign w_b_zero  = (r_b[30:0] == 31'd0);
  assign w_b_inf   = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_b_nan   = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_b_snan  = w_b_nan && !r_b[22];
  assign w_sign    = r_a[31] ^ r_b[31];
  assign w_exp_sum = unpack_exp(r_a) + unpack_exp(r_b) - 10'sd127;

  // Special operand combinations bypass the arithmetic result.
  always_comb begin
    w_spec     = 1'b0;
    w_spec_nv  = 1'b0;
    w_spec_res = 32'd0;
    if (w_a_nan || w_b_nan) begin
      w_spec     = 1'b1;
      w_spec_res = QNAN;
      w_spec_nv  = w_a_snan || w_b_snan;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_spec     = 1'b1;
      w_spec_res = QNAN;
      w_spec_nv  = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sign, 31'd0};
    end
  end

  // Next-state and accept decode; IDLE and DONE both take new work.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_in) begin
          w_accept = 1'b1;
          w_next   = S_UNPACK;
        end
      end
      S_UNPACK: w_next = S_MUL;
      S_MUL:    if (r_cnt == CNT_LAST) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE: begin
        if (bus.valid_in) begin
          w_accept = 1'b1;
          w_next   = S_UNPACK;
        end else begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  logic [24:0] w_psum;
  assign w_psum = {1'b0, r_acc[47:24]} + (r_acc[0] ? {1'b0, r_mcand} : 25'd0);

  // Operand latch, unpack and multiply datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rm       <= 3'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_sign     <= 1'b0;
      r_exp      <= 10'sd0;
      r_mcand    <= 24'd0;
      r_acc      <= 48'd0;
      r_cnt      <= 5'd0;
      r_special  <= 1'b0;
      r_spec_res <= 32'd0;
      r_spec_nv  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rm <= bus.rm;
        r_a  <= bus.multiplicand;
        r_b  <= bus.multiplier;
      end
      if (r_state == S_UNPACK) begin
        r_sign     <= w_sign;
        r_exp      <= w_exp_sum;
        r_mcand    <= unpack_sig(r_a);
        r_acc      <= {24'd0, unpack_sig(r_b)};
        r_cnt      <= 5'd0;
        r_special  <= w_spec;
        r_spec_res <= w_spec_res;
        r_spec_nv  <= w_spec_nv;
      end
      if (r_state == S_MUL) begin
        r_acc <= {w_psum, r_acc[23:1]};
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // Normalize / round datapath.
  logic [47:0]       w_x, w_xs;
  logic signed [9:0] w_exp_n, w_sh_full;
  logic              w_tiny_in;
  logic [4:0]        w_sh;
  logic              w_lost, w_guard, w_rbit, w_sticky, w_inexact, w_inc;
  logic [9:0]        w_exp_base;
  logic [32:0]       w_rsum;
  logic              w_ovf, w_tiny_out;
  logic [31:0]       w_ovf_res, w_res;

  // Product leading one is moved to bit 47 losslessly; tiny results are
  // denormalized before rounding so the carry into the exponent field
  // handles both subnormal->normal and mantissa-overflow renormalization.
  always_comb begin
    w_x       = r_acc[47] ? r_acc : {r_acc[46:0], 1'b0};
    w_exp_n   = r_exp + $signed({9'd0, r_acc[47]});
    w_tiny_in = (w_exp_n < 10'sd1);
    w_sh_full = 10'sd1 - w_exp_n;
    w_sh      = 5'd0;
    if (w_tiny_in) w_sh = (w_sh_full > 10'sd26) ? 5'd26 : w_sh_full[4:0];
    w_lost    = |(w_x & ~({48{1'b1}} << w_sh));
    w_xs      = w_x >> w_sh;
    w_guard   = w_xs[23];
    w_rbit    = w_xs[22];
    w_sticky  = (|w_xs[21:0]) | w_lost;
    w_inexact = w_guard | w_rbit | w_sticky;

    case (r_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & w_inexact;
      3'b011:  w_inc = ~r_sign & w_inexact;
      3'b100:  w_inc = w_guard;
      default: w_inc = w_guard & (w_rbit | w_sticky | w_xs[24]);
    endcase

    // Hidden bit at position 23 contributes the final +1 to the exponent.
    w_exp_base = w_tiny_in ? 10'd0 : $unsigned(w_exp_n - 10'sd1);
    w_rsum     = {w_exp_base, 23'd0} + {9'd0, w_xs[47:24]} + {32'd0, w_inc};
    w_ovf      = (w_rsum[32:23] >= 10'd255);
    w_tiny_out = (w_rsum[32:23] == 10'd0);

    case (r_rm)
      3'b001:  w_ovf_res = {r_sign, 31'h7F7F_FFFF};
      3'b010:  w_ovf_res = r_sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
      3'b011:  w_ovf_res = r_sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
      default: w_ovf_res = {r_sign, 31'h7F80_0000};
    endcase

    w_res = w_ovf ? w_ovf_res : {r_sign, w_rsum[30:0]};
  end

  // Result and flag registers, loaded on the ROUND cycle and held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_product <= 32'd0;
      r_nv      <= 1'b0;
      r_of      <= 1'b0;
      r_uf      <= 1'b0;
      r_nx      <= 1'b0;
    end else if (r_state == S_ROUND) begin
      if (r_special) begin
        r_product <= r_spec_res;
        r_nv      <= r_spec_nv;
        r_of      <= 1'b0;
        r_uf      <= 1'b0;
        r_nx      <= 1'b0;
      end else begin
        r_product <= w_res;
        r_nv      <= 1'b0;
        r_of      <= w_ovf;
        r_uf      <= w_tiny_out & w_inexact;
        r_nx      <= w_inexact | w_ovf;
      end
    end
  end

  assign bus.valid_out = (r_state == S_DONE);
  assign bus.product   = r_product;
  assign bus.nv        = r_nv;
  assign bus.dz        = 1'b0;
  assign bus.of        = r_of;
  assign bus.uf        = r_uf;
  assign bus.nx        = r_nx;
endmodule

// File: tb/tb_mul_fp32.sv
// Directed and back-to-back checks for the iterative binary32 multiplier.
module tb_mul_fp32;
  localparam int LAT = 26;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mul_fp32_if bus();

  mul_fp32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [4:0] w_flags;
  assign w_flags = {bus.nv, bus.dz, bus.of, bus.uf, bus.nx};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  // Independent model for normal operands with a normal result:
  // integer product, remainder-vs-half rounding. Returns {nx, product}.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic [63:0] p, q, rem, half;
    int          e, sh;
    logic        s, up;
    s  = a[31] ^ b[31];
    p  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = 23;
    if (p[47]) begin
      sh = 24;
      e++;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + {63'd0, up};
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    return {rem != 0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [7:0] e;
    e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    bus.valid_in     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.rm           = m;
    @(posedge clock);
    #1 bus.valid_in = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!bus.valid_out && lat < 60);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] m, input logic [31:0] ep, input logic [4:0] ef);
    int lat;
    @(negedge clock);
    drive_op(a, b, m);
    wait_result(lat);
    check_val({tag, ".lat"}, 32'(lat), 32'(LAT));
    check_val({tag, ".p"}, bus.product, ep);
    check_val({tag, ".flags"}, 32'(w_flags), 32'(ef));
    @(posedge clock);
    #1 check_val({tag, ".pulse"}, 32'(bus.valid_out), 32'd0);
  endtask

  logic [31:0] ca, cb, got_p;
  logic [2:0]  cm;
  logic [32:0] cexp;
  int          lat, pulses;

  initial begin
    bus.valid_in     = 1'b0;
    bus.rm           = 3'd0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst0.valid", 32'(bus.valid_out), 32'd0);
    check_val("rst0.p", bus.product, 32'd0);
    check_val("rst0.flags", 32'(w_flags), 32'd0);
    @(negedge clock) reset = 1'b0;

    // flags order: {nv, dz, of, uf, nx}
    run_vec("basic",     32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000);
    run_vec("infx0",     32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000);
    run_vec("snan",      32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000);
    run_vec("qnan",      32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000);
    run_vec("inf_fin",   32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000);
    run_vec("zero_fin",  32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000);
    run_vec("ovf_rne",   32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101);
    run_vec("ovf_rtz",   32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101);
    run_vec("ovf_rdn_p", 32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F7FFFFF, 5'b00101);
    run_vec("ovf_rdn_n", 32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b00101);
    run_vec("ovf_rup_n", 32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101);
    run_vec("sub_exact", 32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'b00000);
    run_vec("sub_tie",   32'h00800001, 32'h3F000000, 3'd0, 32'h00400000, 5'b00011);
    run_vec("sub_in",    32'h00000001, 32'h4B000000, 3'd0, 32'h00800000, 5'b00000);
    run_vec("to_zero",   32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011);
    run_vec("min_sub",   32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'b00011);
    run_vec("rnd_rne",   32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001);
    run_vec("rnd_rup",   32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001);
    run_vec("rnd_rtz",   32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00001);
    run_vec("rnd_rm5",   32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800002, 5'b00001);

    // Back-to-back: each new op issued during the previous valid_out cycle.
    ca = rand_norm(); cb = rand_norm(); cm = 3'($urandom_range(0, 4));
    cexp = ref_mul(ca, cb, cm);
    @(negedge clock);
    drive_op(ca, cb, cm);
    for (int i = 0; i < 10; i++) begin
      wait_result(lat);
      check_val($sformatf("b2b%0d.lat", i), 32'(lat), 32'(LAT));
      check_val($sformatf("b2b%0d.p", i), bus.product, cexp[31:0]);
      check_val($sformatf("b2b%0d.flags", i), 32'(w_flags), {31'd0, cexp[32]});
      if (i < 9) begin
        ca = rand_norm(); cb = rand_norm(); cm = 3'($urandom_range(0, 4));
        cexp = ref_mul(ca, cb, cm);
        drive_op(ca, cb, cm);
      end
    end
    @(posedge clock);
    #1 check_val("b2b.idle", 32'(bus.valid_out), 32'd0);

    // valid_in while busy must be ignored.
    @(negedge clock);
    drive_op(32'h3FC00000, 32'h40000000, 3'd0);
    repeat (5) @(posedge clock);
    #1;
    bus.valid_in     = 1'b1;
    bus.multiplicand = 32'h40400000;
    @(posedge clock);
    #1 bus.valid_in = 1'b0;
    pulses = 0;
    got_p  = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock);
      #1;
      if (bus.valid_out) begin
        pulses++;
        got_p = bus.product;
      end
    end
    check_val("busy.pulses", 32'(pulses), 32'd1);
    check_val("busy.p", got_p, 32'h40400000);

    // Reset during MUL cycle 10: outputs clear at once, no valid_out follows.
    @(negedge clock);
    drive_op(32'h3F800001, 32'h3F800001, 3'd0);
    repeat (11) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_val("rst.p", bus.product, 32'd0);
    check_val("rst.flags", 32'(w_flags), 32'd0);
    check_val("rst.valid", 32'(bus.valid_out), 32'd0);
    @(negedge clock) reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.valid_out) pulses++;
    end
    check_val("rst.pulses", 32'(pulses), 32'd0);

    run_vec("after_rst", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul_fp32.md
Name: mul_fp32

Overview:
- Iterative single-precision IEEE-754 multiplier; the companion to div_fp32 in the arithmetic-unit library.
- Its valid_in/valid_out handshake, rounding-mode encoding and exception-flag set match div_fp32, so both units plug into the same FPU issue/writeback path.
- Uses a radix-2 shift-add mantissa multiplier over 24 cycles, then one normalize/round cycle.
- Fixed latency regardless of operand class.

Parameters:
- LATENCY, 26, cycles from the accepting clock edge to the edge that raises valid_out. Fixed by the architecture; exposed for bench use only. Must not be overridden.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  operands valid; sampled only when the unit is ready
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE
- multiplicand  input  32  IEEE-754 binary32 operand A
- multiplier  input  32  IEEE-754 binary32 operand B
- valid_out  output  1  one-cycle pulse; result and flags valid
- product  output  32  binary32 result
- nv  output  1  invalid operation
- dz  output  1  divide-by-zero; tied 0 for multiply
- of  output  1  overflow
- uf  output  1  underflow
- nx  output  1  inexact

Behaviour:
- Reset (asynchronous, active-high) state:
  - FSM returns to IDLE immediately.
  - valid_out=0, product=0, all flags=0.
  - Internal counter, accumulator and sticky bit cleared.
  - Reset mid-operation abandons the operation; no valid_out follows.
- FSM states: IDLE → UNPACK → MUL → ROUND → DONE.
- IDLE, and the DONE cycle, are ready states. valid_in=1 on a ready edge latches rm and both operands and enters UNPACK.
- Back-to-back: valid_in asserted during the valid_out cycle is accepted on that edge. Zero bubble between operations; throughput is 1 op per 26 cycles.
- valid_in while in UNPACK/MUL/ROUND is ignored. No queueing, no error.
- UNPACK (1 cycle):
  - Classify each operand: zero, subnormal, normal, inf, qNaN, sNaN.
  - Form 24-bit significands, hidden bit 1 for normals.
  - Normalize subnormal significands with a leading-zero count and adjust the exponent.
  - Compute sign = signA ^ signB and the biased exponent sum expA + expB − 127 as signed 10 bits.
- MUL (24 cycles): 5-bit counter 0..23. Each cycle, if the current multiplier bit is 1, add the multiplicand into a 48-bit partial product; then shift.
- ROUND (1 cycle):
  - If bit 47 of the 48-bit product is set, shift right 1 and increment the exponent.
  - If exponent ≤ 0, right-shift the significand by (1 − exponent), capped at 26, OR-ing shifted-out bits into sticky (gradual underflow).
  - Round using guard/round/sticky per rm. A rounding carry out renormalizes.
  - Exponent ≥ 255 after rounding → overflow.
- DONE: valid_out=1 for exactly one cycle with product and flags. Outputs hold their values until the next DONE or reset.
- Special cases: computed in UNPACK and held; still delivered at fixed LATENCY.
  - Any NaN operand → 0x7FC00000 (canonical). nv=1 only if an operand is sNaN.
  - inf × 0 → 0x7FC00000, nv=1.
  - inf × finite nonzero → signed inf, no flags.
  - zero × finite → signed zero, no flags.
- Overflow result by rm:
  - RNE/RMM → signed inf.
  - RTZ → signed max-normal 0x7F7FFFFF.
  - RDN → +max-normal or −inf.
  - RUP → +inf or −max-normal.
  - of=1 and nx=1 in all cases.
- Underflow: uf=1 only when the result is tiny after rounding and inexact. Exact subnormal results give uf=0, nx=0.
- nx=1 whenever any guard/round/sticky bit is nonzero, or on overflow.

Test Plan:
- 0x3FC00000 × 0x40000000, rm=000 → product 0x40400000, flags 0. valid_out exactly 26 cycles after the accepting edge, high for 1 cycle.
- 0x7F800000 × 0x00000000 → 0x7FC00000, nv=1, others 0. 0x7F800001 (sNaN) × 0x3F800000 → 0x7FC00000, nv=1.
- 0x7F7FFFFF × 0x40000000, rm=000 → 0x7F800000, of=1, nx=1. Same operands with rm=001 → 0x7F7FFFFF, of=1, nx=1.
- 0x00800000 × 0x3F000000 → 0x00400000, uf=0, nx=0. 0x00800001 × 0x3F000000, rm=000 → 0x00400000, uf=1, nx=1.
- 0x3F800001 × 0x3F800001: rm=000 → 0x3F800002, nx=1; rm=011 → 0x3F800003, nx=1; rm=001 → 0x3F800002.
- Handshake and reset:
  - Issue a new valid_in in each valid_out cycle for 10 random ops. Each must be accepted with no bubble and checked against a reference model.
  - Assert reset in MUL cycle 10: valid_out stays 0, outputs clear immediately.
  - A valid_in pulse during a busy cycle produces no extra valid_out.
